rot_sub_word: RTL and testbench



---
 rtl/rot_sub_word.sv | 91 +++++++++
 tb/tb_rot_sub_word.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rot_sub_word.sv
// AES key-schedule word transform: SubWord(RotWord(w)) or SubWord(w), optional Rcon XOR (`RCON_XOR_EN).
// Latency: 1 cycle to word_out/out_valid; rot_out is combinational.
// Backpressure: none, a new word is accepted every cycle.
module rot_sub_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        rot_en,
    input  logic [0:31] word_in,
`ifdef RCON_XOR_EN
    input  logic [3:0]  rcon_idx,
`endif
    output logic [0:31] rot_out,
    output logic [0:31] word_out,
    output logic        out_valid
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [0:31] sel_word;
    logic [0:31] sub_word;
    logic [0:31] t_d;
    logic [0:31] word_q;
    logic        vld_q;

    assign rot_out  = {word_in[8:31], word_in[0:7]};
    assign sel_word = rot_en ? rot_out : word_in;

    // Byte k occupies bits 8k..8k+7, bit 8k being the byte MSB.
    for (genvar k = 0; k < 4; k++) begin : g_sbox
        assign sub_word[8*k +: 8] = SBOX[sel_word[8*k +: 8]];
    end

`ifdef RCON_XOR_EN
    logic [7:0] rcon_byte;

    always_comb begin
        rcon_byte = 8'h00;
        case (rcon_idx)
            4'd1:    rcon_byte = 8'h01;
            4'd2:    rcon_byte = 8'h02;
            4'd3:    rcon_byte = 8'h04;
            4'd4:    rcon_byte = 8'h08;
            4'd5:    rcon_byte = 8'h10;
            4'd6:    rcon_byte = 8'h20;
            4'd7:    rcon_byte = 8'h40;
            4'd8:    rcon_byte = 8'h80;
            4'd9:    rcon_byte = 8'h1b;
            4'd10:   rcon_byte = 8'h36;
            default: rcon_byte = 8'h00;
        endcase
    end

    assign t_d = sub_word ^ {rcon_byte, 24'h000000};
`else
    assign t_d = sub_word;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                word_q <= t_d;
            end
        end
    end

    assign word_out  = word_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_rot_sub_word.sv
// Directed bench for rot_sub_word with a queue scoreboard; expected words are FIPS-197 values.
module tb_rot_sub_word;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        rot_en;
    logic [0:31] word_in;
    logic [0:31] rot_out;
    logic [0:31] word_out;
    logic        out_valid;
`ifdef RCON_XOR_EN
    logic [3:0]  rcon_idx;
    logic [7:0]  rc_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [31:0] EXP_W3 = 32'h8b84eb01;
    localparam logic [31:0] EXP_W7 = 32'h52386be5;
`else
    localparam logic [31:0] EXP_W3 = 32'h8a84eb01;
    localparam logic [31:0] EXP_W7 = 32'h50386be5;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    rot_sub_word dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .rot_en    (rot_en),
        .word_in   (word_in),
`ifdef RCON_XOR_EN
        .rcon_idx  (rcon_idx),
`endif
        .rot_out   (rot_out),
        .word_out  (word_out),
        .out_valid (out_valid)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious out_valid", {31'b0, out_valid}, 32'h0);
            end else begin
                check("word_out", word_out, sb_q.pop_front());
            end
        end
    end

    // Called at posedge+1; drives one word, checks rot_out, returns at the next posedge+1.
    task automatic drive(input logic [31:0] w, input logic r, input logic [3:0] rc,
                         input logic [31:0] exp_rot, input logic [31:0] exp_out);
        in_valid = 1'b1;
        word_in  = w;
        rot_en   = r;
`ifdef RCON_XOR_EN
        rcon_idx = rc;
`endif
        #1;
        check("rot_out", rot_out, exp_rot);
        sb_q.push_back(exp_out);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        rot_en   = 1'b1;
        word_in  = 32'h09cf4f3c;
`ifdef RCON_XOR_EN
        rcon_idx = 4'd1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset word_out", word_out, 32'h0);
        check("reset out_valid", {31'b0, out_valid}, 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(32'h09cf4f3c, 1'b1, 4'd1, 32'hcf4f3c09, EXP_W3);
        drive(32'h2a6c7605, 1'b1, 4'd2, 32'h6c76052a, EXP_W7);
        drive(32'h0053ff00, 1'b0, 4'd0, 32'h53ff0000, 32'h63ed1663);
`ifdef RCON_XOR_EN
        drive(32'h0053ff00, 1'b0, 4'd11, 32'h53ff0000, 32'h63ed1663);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle out_valid", {31'b0, out_valid}, 32'h0);
        check("idle hold", word_out, 32'h63ed1663);
        @(posedge clk);
        #1;

        drive(32'h00000000, 1'b1, 4'd0, 32'h00000000, 32'h63636363);
        drive(32'h09cf4f3c, 1'b1, 4'd0, 32'hcf4f3c09, 32'h8a84eb01);
        drive(32'h2a6c7605, 1'b1, 4'd0, 32'h6c76052a, 32'h50386be5);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stream out_valid low", {31'b0, out_valid}, 32'h0);
        check("stream hold", word_out, 32'h50386be5);
        @(posedge clk);
        @(negedge clk);
        check("stream hold 2", word_out, 32'h50386be5);
        @(posedge clk);
        #1;

`ifdef RCON_XOR_EN
        for (int i = 1; i <= 10; i++) begin
            drive(32'h00000000, 1'b1, 4'(i), 32'h00000000, {8'h63 ^ rc_tab[i], 24'h636363});
        end
`endif

        // Asynchronous reset between clock edges clears a captured result at once.
        drive(32'h09cf4f3c, 1'b1, 4'd0, 32'hcf4f3c09, 32'h8a84eb01);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async reset word_out", word_out, 32'h0);
        check("async reset out_valid", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b1;
        word_in  = 32'h2a6c7605;
        @(posedge clk);
        #1;
        check("reset held word_out", word_out, 32'h0);
        reset = 1'b1;
        drive(32'h2a6c7605, 1'b1, 4'd2, 32'h6c76052a, EXP_W7);
        in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
